// File: rtl/dir_queue.sv
`default_nettype none
// ============================================================================
// dir_queue : synchronised button edges, heading FIFO and move-tick generator
// rev 1.0
// ============================================================================
module dir_queue #(
  parameter int TICK_BASE = 1000000,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             dir_pb,
  input  logic                   pause_pb,
  input  logic                   game_over,
  input  logic [1:0]             speed,
  output logic                   move_tick,
  output logic [1:0]             direction,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int QW = AW + 1;
  localparam int CW = $clog2(TICK_BASE * 4 + 1);

  localparam logic [QW-1:0] c_full = QW'(DEPTH);
  localparam logic [CW-1:0] c_p0   = CW'(TICK_BASE * 4);
  localparam logic [CW-1:0] c_p1   = CW'(TICK_BASE * 3);
  localparam logic [CW-1:0] c_p2   = CW'(TICK_BASE * 2);
  localparam logic [CW-1:0] c_p3   = CW'(TICK_BASE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t          r_state;
  logic [3:0]      r_dir_s1, r_dir_s2, r_dir_d;
  logic            r_pau_s1, r_pau_s2, r_pau_d;
  logic [1:0]      r_dir;
  logic [1:0]      r_fifo [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [QW-1:0]   r_count;
  logic [CW-1:0]   r_cnt, r_period;
  logic            r_tick, r_ovf;

  logic [3:0]      w_dir_edge;
  logic            w_pause_edge;
  logic            w_dir_req;
  logic [1:0]      w_dir_val;
  logic [AW-1:0]   w_tail_idx;
  logic [1:0]      w_ref;
  logic            w_accept;
  logic            w_wrap;
  logic            w_pop;
  logic            w_push;
  logic [CW-1:0]   w_period_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dir_s1 <= 4'd0;
      r_dir_s2 <= 4'd0;
      r_dir_d  <= 4'd0;
      r_pau_s1 <= 1'b0;
      r_pau_s2 <= 1'b0;
      r_pau_d  <= 1'b0;
    end else begin
      r_dir_s1 <= dir_pb;
      r_dir_s2 <= r_dir_s1;
      r_dir_d  <= r_dir_s2;
      r_pau_s1 <= pause_pb;
      r_pau_s2 <= r_pau_s1;
      r_pau_d  <= r_pau_s2;
    end
  end

  assign w_dir_edge   = r_dir_s2 & ~r_dir_d;
  assign w_pause_edge = r_pau_s2 & ~r_pau_d;

  always_comb begin
    w_dir_req = 1'b1;
    w_dir_val = 2'd0;
    if (w_dir_edge[0])      w_dir_val = 2'd0;
    else if (w_dir_edge[1]) w_dir_val = 2'd1;
    else if (w_dir_edge[2]) w_dir_val = 2'd2;
    else if (w_dir_edge[3]) w_dir_val = 2'd3;
    else                    w_dir_req = 1'b0;

    w_tail_idx = r_wr - AW'(1);
    w_ref      = (r_count != '0) ? r_fifo[w_tail_idx] : r_dir;
    // Encoding puts each axis in bit 1, so same axis means equal or reverse.
    w_accept   = w_dir_req && (w_dir_val[1] != w_ref[1]);

    w_wrap = (r_cnt == r_period - CW'(1));
    w_pop  = w_wrap && (r_count != '0);
    w_push = w_accept && ((r_count != c_full) || w_pop);

    case (speed)
      2'd0:    w_period_sel = c_p0;
      2'd1:    w_period_sel = c_p1;
      2'd2:    w_period_sel = c_p2;
      default: w_period_sel = c_p3;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dir    <= 2'd3;
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_cnt    <= '0;
      r_period <= c_p0;
      r_tick   <= 1'b0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= 2'd0;
    end else begin
      r_tick <= 1'b0;
      r_ovf  <= 1'b0;
      if (game_over) begin
        r_state <= S_OVER;
        r_wr    <= '0;
        r_rd    <= '0;
        r_count <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt    <= '0;
            r_period <= w_period_sel;
            if (w_accept) begin
              r_dir   <= w_dir_val;
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            if (w_pause_edge) begin
              r_state <= S_PAUSE;
            end else begin
              if (w_wrap) begin
                r_cnt    <= '0;
                r_period <= w_period_sel;
                r_tick   <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
              // Pop reads the old head; a coincident push lands at the tail.
              if (w_pop) begin
                r_dir <= r_fifo[r_rd];
                r_rd  <= r_rd + AW'(1);
              end
              if (w_push) begin
                r_fifo[r_wr] <= w_dir_val;
                r_wr         <= r_wr + AW'(1);
              end
              if (w_accept && !w_push) r_ovf <= 1'b1;
              if (w_push && !w_pop)      r_count <= r_count + QW'(1);
              else if (w_pop && !w_push) r_count <= r_count - QW'(1);
            end
          end
          S_PAUSE: begin
            if (w_pause_edge) r_state <= S_RUN;
          end
          default: begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign move_tick   = r_tick;
  assign direction   = r_dir;
  assign state       = r_state;
  assign queue_count = r_count;
  assign overflow    = r_ovf;

endmodule
`default_nettype wire
